ps2_scancode_rx: RTL and testbench
==================================

Name: ps2_scancode_rx

Overview:
Parametrised PS/2 keyboard receiver running entirely in the system clock domain. It oversamples PS2Clk/PS2Data, deglitches the clock line, frames and checks 11-bit packets, and folds E0/F0 prefixes into per-key extended/break flags. Decoded keys are buffered in a FIFO with a valid/ready handshake toward the game controller. It replaces the free-running shift-register detector, which has no parity, stop or timeout checks and no buffering.

Parameters:
FILTER_LEN, 8, consecutive identical synced PS2Clk samples required before the filtered clock changes state (>=2)
TIMEOUT_CYCLES, 100000, CLK cycles without a filtered falling edge before a partial frame is abandoned (1 ms at 100 MHz)
FIFO_DEPTH, 8, key FIFO entries, power of two, >=2

Ports:
CLK  in  1  system clock, all logic on posedge
RST  in  1  synchronous reset, active-high
PS2Clk  in  1  raw PS/2 clock (asynchronous)
PS2Data  in  1  raw PS/2 data (asynchronous)
code_out  out  8  scancode at FIFO head
ext_out  out  1  head key was preceded by E0
brk_out  out  1  head key was preceded by F0 (release)
valid  out  1  FIFO non-empty
ready  in  1  consumer accepts head when valid&&ready
frame_err  out  1  one-cycle pulse: bad start/parity/stop or timeout
overflow  out  1  one-cycle pulse: decoded key dropped because FIFO full

Behaviour:
- Reset: FSM=IDLE, FIFO empty, valid=0, frame_err=0, overflow=0, prefix flags cleared, filtered clock=1, synchronisers=1. Reset mid-frame abandons the frame with no error pulse.
- Sync: 2-FF synchroniser on each input. Filter: counter increments while synced PS2Clk != filtered value; filtered value flips when count reaches FILTER_LEN-1; any matching sample clears count.
- fall = filtered clock 1->0 (single-cycle strobe); data sampled from synced PS2Data that cycle.
- FSM IDLE: fall with data=0 -> RECV, bit_cnt=1. Fall with data=1 -> stay IDLE, no error.
- RECV: each fall shifts the bit in LSB-first and increments bit_cnt. The fall delivering bit 10 (stop) -> CHECK.
- Timeout: counter clears on every fall. In RECV, reaching TIMEOUT_CYCLES -> IDLE, frame_err pulse, prefix flags cleared.
- CHECK (exactly one cycle, then IDLE): pass iff XOR(data[7:0],parity)=1 and stop=1.
  - Fail: frame_err pulse, prefix flags cleared, nothing written.
  - Pass, byte 0xE0: set ext_pend.
  - Pass, byte 0xF0: set brk_pend.
  - Pass, other byte: write {ext_pend,brk_pend,byte} to FIFO, then clear both pending flags.
  - Prefix flags persist across frames until consumed or cleared.
- Latency: FIFO write occurs in the CHECK cycle, i.e. the cycle after the stop-bit fall. valid/outputs update the following cycle.
- FIFO: first-word fall-through; head outputs are don't-care when valid=0.
  - Pop when valid&&ready.
  - Push while full with no pop: entry dropped, overflow pulses, contents unchanged.
  - Push while full with simultaneous pop: both occur, no overflow.
  - Push while empty: valid rises next cycle. Pop of the last entry: valid falls next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is clog2(FIFO_DEPTH)+1.
- Host-to-device transmission is not supported. Both lines are inputs only.

Test Plan:
- Frame 0x1C (bits 0,0,0,1,1,1,0,0,0,parity 0,stop 1), 50 us bit period, ready=1 -> one entry code_out=0x1C, ext=0, brk=0, valid high for 1 cycle, no frame_err.
- Send E0, F0, 75 -> exactly one entry: code_out=0x75, ext_out=1, brk_out=1. Then send 75 -> ext=0, brk=0.
- Frame 0x1C with parity=1 -> frame_err single pulse, FIFO stays empty. A following valid 0x1C is accepted normally.
- Start bit plus 4 bits, then PS2Clk held high for TIMEOUT_CYCLES -> frame_err pulse, FSM back to IDLE. Next full frame 0x29 decodes correctly.
- ready=0, send 9 distinct codes with FIFO_DEPTH=8 -> overflow pulses once on the 9th. Draining yields the first 8 codes in order, then valid=0.
- PS2Clk glitch low for FILTER_LEN-2 cycles mid-frame -> no extra bit shifted, frame decodes correctly. RST asserted after bit 5 -> outputs at reset values, next frame decodes correctly.

Source files
------------

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronise, deglitch, frame and check 11-bit packets.
// E0/F0 prefixes fold into per-key flags; keys are queued in a fall-through FIFO.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic [7:0] code_out,
  output logic       ext_out,
  output logic       brk_out,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [FW-1:0] F_MAX  = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          filt, filt_q;
  logic [FW-1:0] fcnt;
  logic          fall;

  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      filt   <= 1'b1;
      filt_q <= 1'b1;
      fcnt   <= '0;
    end else begin
      clk_s1 <= PS2Clk;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2Data;
      dat_s2 <= dat_s1;
      filt_q <= filt;
      if (clk_s2 != filt) begin
        if (fcnt == F_MAX) begin
          filt <= clk_s2;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  assign fall = filt_q & ~filt;

  state_t        state;
  logic [9:0]    sh;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] tcnt;
  logic          ext_pend, brk_pend;
  logic          pass, is_e0, is_f0;

  // sh[7:0] data, sh[8] parity, sh[9] stop once ten bits are in
  assign pass  = (^sh[8:0]) & sh[9];
  assign is_e0 = (sh[7:0] == 8'hE0);
  assign is_f0 = (sh[7:0] == 8'hF0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      sh        <= '0;
      bit_cnt   <= '0;
      tcnt      <= '0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (fall)
        tcnt <= '0;
      else if (state == RECV)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;
      unique case (state)
        IDLE: begin
          if (fall && !dat_s2) begin
            state   <= RECV;
            bit_cnt <= 4'd1;
          end
        end
        RECV: begin
          if (fall) begin
            sh      <= {dat_s2, sh[9:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd10)
              state <= CHECK;
          end else if (tcnt == TO_MAX) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
          end
        end
        CHECK: begin
          state <= IDLE;
          if (!pass) begin
            frame_err <= 1'b1;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
          end else if (is_e0) begin
            ext_pend <= 1'b1;
          end else if (is_f0) begin
            brk_pend <= 1'b1;
          end else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          push, pop, full, wr;

  assign push = (state == CHECK) && pass && !is_e0 && !is_f0;
  assign full = (cnt == DEPTH);
  assign pop  = valid & ready;
  assign wr   = push & (~full | pop);

  always_ff @(posedge CLK) begin
    if (wr)
      mem[wptr] <= {ext_pend, brk_pend, sh[7:0]};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & full & ~pop;
      if (wr)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      case ({wr, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign valid = (cnt != '0);
  assign {ext_out, brk_out, code_out} = mem[rptr];

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Randomised self-checking bench for ps2_scancode_rx.
// A frame-level model predicts queued keys, error pulses and overflow.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;

  localparam int FL = 8;
  localparam int TO = 2000;
  localparam int FD = 8;
  localparam int H  = 40;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PS2Clk = 1'b1;
  logic       PS2Data = 1'b1;
  logic [7:0] code_out;
  logic       ext_out, brk_out, valid, ready;
  logic       frame_err, overflow;

  ps2_scancode_rx #(
    .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(FD)
  ) dut (
    .CLK(CLK), .RST(RST), .PS2Clk(PS2Clk), .PS2Data(PS2Data),
    .code_out(code_out), .ext_out(ext_out), .brk_out(brk_out),
    .valid(valid), .ready(ready),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  bit rnd_rdy = 0;
  bit rdy_force = 1;
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  logic [9:0] got[$];
  int err_cyc = 0, ov_cyc = 0, vcyc = 0;
  always @(negedge CLK) begin
    if (valid && ready) got.push_back({ext_out, brk_out, code_out});
    if (frame_err) err_cyc++;
    if (overflow) ov_cyc++;
    if (valid) vcyc++;
  end

  logic [9:0] exp_q[$];
  bit m_ext = 0, m_brk = 0;
  int m_err = 0;

  task automatic cyc(input int k);
    repeat (k) @(posedge CLK);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n, input int glitch);
    for (int i = 0; i < n; i++) begin
      PS2Data = f[i];
      if (i == glitch) begin
        cyc(H / 4);
        PS2Clk = 1'b0;
        cyc(FL - 2);
        PS2Clk = 1'b1;
        cyc(H - H / 4 - (FL - 2));
      end else begin
        cyc(H);
      end
      PS2Clk = 1'b0;
      cyc(H);
      PS2Clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b, input bit bad);
    return {1'b1, (~^b) ^ bad, b, 1'b0};
  endfunction

  // Frame-level model: odd parity, prefixes accumulate until a key lands
  task automatic send_byte(input logic [7:0] b, input bit bad, input int glitch);
    send_bits(mkframe(b, bad), 11, glitch);
    PS2Data = 1'b1;
    cyc(30);
    if (bad) begin
      m_err++;
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      exp_q.push_back({m_ext, m_brk, b});
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    cyc(4);
    checks++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else passes++;
    checks++; if (frame_err !== 1'b0) $display("FAIL reset_err got %b want 0", frame_err); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else passes++;
    RST = 1'b0;
    cyc(10);
    checks++; if (valid !== 1'b0) $display("FAIL idle_valid got %b want 0", valid); else passes++;
  endtask

  task automatic test_basic;
    int base, e0, v0;
    base = got.size(); e0 = err_cyc; v0 = vcyc;
    exp_q.delete();
    send_byte(8'h1C, 0, -1);
    checks++; if (got.size() - base !== 1) $display("FAIL basic_cnt got %0d want 1", got.size() - base); else passes++;
    if (got.size() > base) begin
      checks++; if (got[base] !== exp_q[0]) $display("FAIL basic_key got %h want %h", got[base], exp_q[0]); else passes++;
    end
    checks++; if (vcyc - v0 !== 1) $display("FAIL basic_vcyc got %0d want 1", vcyc - v0); else passes++;
    checks++; if (err_cyc !== e0) $display("FAIL basic_err got %0d want %0d", err_cyc, e0); else passes++;
  endtask

  task automatic test_prefix;
    int base;
    base = got.size();
    exp_q.delete();
    send_byte(8'hE0, 0, -1);
    send_byte(8'hF0, 0, -1);
    checks++; if (got.size() !== base) $display("FAIL prefix_nokey got %0d want %0d", got.size(), base); else passes++;
    send_byte(8'h75, 0, -1);
    send_byte(8'h75, 0, -1);
    checks++; if (got.size() - base !== 2) $display("FAIL prefix_cnt got %0d want 2", got.size() - base); else passes++;
    for (int i = 0; i < 2 && base + i < got.size(); i++) begin
      checks++; if (got[base+i] !== exp_q[i]) $display("FAIL prefix_key%0d got %h want %h", i, got[base+i], exp_q[i]); else passes++;
    end
  endtask

  task automatic test_parity;
    int base, e0;
    base = got.size(); e0 = err_cyc;
    exp_q.delete();
    send_byte(8'h1C, 1, -1);
    checks++; if (err_cyc - e0 !== 1) $display("FAIL parity_err got %0d want 1", err_cyc - e0); else passes++;
    checks++; if (got.size() !== base) $display("FAIL parity_nokey got %0d want %0d", got.size(), base); else passes++;
    send_byte(8'h1C, 0, -1);
    checks++; if (got.size() - base !== 1) $display("FAIL parity_next got %0d want 1", got.size() - base); else passes++;
    if (got.size() > base) begin
      checks++; if (got[base] !== exp_q[0]) $display("FAIL parity_key got %h want %h", got[base], exp_q[0]); else passes++;
    end
  endtask

  task automatic test_timeout;
    int base, e0;
    base = got.size();
    exp_q.delete();
    send_byte(8'hE0, 0, -1);
    e0 = err_cyc;
    send_bits(mkframe(8'h29, 0), 5, -1);
    PS2Data = 1'b1;
    cyc(TO + 300);
    m_ext = 0; m_brk = 0;
    checks++; if (err_cyc - e0 !== 1) $display("FAIL timeout_err got %0d want 1", err_cyc - e0); else passes++;
    send_byte(8'h29, 0, -1);
    checks++; if (got.size() - base !== 1) $display("FAIL timeout_cnt got %0d want 1", got.size() - base); else passes++;
    if (got.size() > base) begin
      checks++; if (got[base] !== exp_q[0]) $display("FAIL timeout_key got %h want %h", got[base], exp_q[0]); else passes++;
    end
  endtask

  task automatic test_overflow;
    int base, o0;
    base = got.size(); o0 = ov_cyc;
    exp_q.delete();
    rdy_force = 0;
    cyc(3);
    for (int i = 0; i < FD + 1; i++) send_byte(8'h10 + 8'(i), 0, -1);
    void'(exp_q.pop_back());
    checks++; if (ov_cyc - o0 !== 1) $display("FAIL ovf_pulse got %0d want 1", ov_cyc - o0); else passes++;
    checks++; if (got.size() !== base) $display("FAIL ovf_held got %0d want %0d", got.size(), base); else passes++;
    rdy_force = 1;
    cyc(FD + 10);
    checks++; if (got.size() - base !== FD) $display("FAIL ovf_drain got %0d want %0d", got.size() - base, FD); else passes++;
    for (int i = 0; i < FD && base + i < got.size(); i++) begin
      checks++; if (got[base+i] !== exp_q[i]) $display("FAIL ovf_key%0d got %h want %h", i, got[base+i], exp_q[i]); else passes++;
    end
    checks++; if (valid !== 1'b0) $display("FAIL ovf_empty got %b want 0", valid); else passes++;
  endtask

  task automatic test_glitch_reset;
    int base, e0;
    exp_q.delete();
    rdy_force = 0;
    cyc(3);
    send_byte(8'h5A, 0, 4);
    checks++; if (valid !== 1'b1) $display("FAIL glitch_valid got %b want 1", valid); else passes++;
    checks++; if ({ext_out, brk_out, code_out} !== exp_q[0]) $display("FAIL glitch_key got %h want %h", {ext_out, brk_out, code_out}, exp_q[0]); else passes++;
    send_byte(8'hE0, 0, -1);
    send_bits(mkframe(8'h29, 0), 6, -1);
    e0 = err_cyc;
    RST = 1'b1;
    cyc(3);
    checks++; if (valid !== 1'b0) $display("FAIL rst_valid got %b want 0", valid); else passes++;
    RST = 1'b0;
    m_ext = 0; m_brk = 0;
    exp_q.delete();
    PS2Data = 1'b1;
    rdy_force = 1;
    cyc(20);
    base = got.size();
    send_byte(8'h29, 0, -1);
    checks++; if (err_cyc !== e0) $display("FAIL rst_err got %0d want %0d", err_cyc, e0); else passes++;
    checks++; if (got.size() - base !== 1) $display("FAIL rst_cnt got %0d want 1", got.size() - base); else passes++;
    if (got.size() > base) begin
      checks++; if (got[base] !== exp_q[0]) $display("FAIL rst_key got %h want %h", got[base], exp_q[0]); else passes++;
    end
  endtask

  task automatic test_random;
    int base, e0, o0, me0, r;
    logic [7:0] b;
    bit bad;
    base = got.size(); e0 = err_cyc; o0 = ov_cyc; me0 = m_err;
    exp_q.delete();
    rnd_rdy = 1;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 7);
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
      bad = ($urandom_range(0, 9) == 0);
      send_byte(b, bad, -1);
    end
    rnd_rdy = 0;
    rdy_force = 1;
    cyc(20);
    checks++; if (got.size() - base !== exp_q.size()) $display("FAIL rnd_cnt got %0d want %0d", got.size() - base, exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
      checks++; if (got[base+i] !== exp_q[i]) $display("FAIL rnd_key%0d got %h want %h", i, got[base+i], exp_q[i]); else passes++;
    end
    checks++; if (err_cyc - e0 !== m_err - me0) $display("FAIL rnd_err got %0d want %0d", err_cyc - e0, m_err - me0); else passes++;
    checks++; if (ov_cyc !== o0) $display("FAIL rnd_ovf got %0d want %0d", ov_cyc, o0); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prefix();
    test_parity();
    test_timeout();
    test_overflow();
    test_glitch_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
